xor_accum_window: RTL and testbench
===================================

# xor_accum_window

Parametrised, multi-bit successor to the single-bit XOR-feedback flip-flop (`dout <= dout ^ din`). It holds a WIDTH-bit running XOR accumulator and a windowed XOR accumulator that closes every WINDOW accepted samples and emits the window result with a one-cycle valid pulse. It sits on the sampled-data path as a parity/signature collector for downstream checkers, and adds input qualification, synchronous clear, and window framing that the single-bit flop lacks.

## Interface
- WIDTH, 8, data width in bits (≥1)
- WINDOW, 16, accepted samples per window (≥2); counter width is clog2(WINDOW)

- clk  in  1  rising-edge clock; only clock in the block
- rst_n  in  1  reset, synchronous, active-low
- din  in  WIDTH  input sample
- din_valid  in  1  qualifies din; a sample is accepted on a rising edge with din_valid=1 and clr=0
- clr  in  1  synchronous clear of the accumulators and window counter
- dout  out  WIDTH  running accumulator
- win_out  out  WIDTH  XOR of the last completed window
- win_valid  out  1  one-cycle pulse when win_out updates
- win_cnt  out  clog2(WINDOW)  samples accepted in the current window

## Operation
- Registers: `dout`, window accumulator `wacc` (internal), `win_cnt`, `win_out`, `win_valid`.
- Accepted sample:
  - `dout <= dout ^ din`.
  - If `win_cnt < WINDOW-1`: `wacc <= wacc ^ din`; `win_cnt <= win_cnt+1`.
  - If `win_cnt == WINDOW-1`: `win_out <= wacc ^ din`; `win_valid <= 1`; `wacc <= 0`; `win_cnt <= 0`.
- No accepted sample: `dout`, `wacc`, `win_cnt`, and `win_out` hold.
- `win_valid` is 0 in every cycle except the one after window closure. It is never held high on consecutive cycles unless WINDOW samples close back-to-back, which is impossible for WINDOW ≥ 2.
- `clr=1`:
  - `dout`, `wacc`, and `win_cnt` are set to 0. `win_valid` is set to 0.
  - `win_out` holds its last value.
  - clr beats din_valid in the same cycle: the sample is dropped, and a window that would have closed does not close.
- `dout` is never cleared by window closure; only clr or reset clears it.
- All arithmetic is bitwise XOR. There is no carry and no overflow. `win_cnt` wraps only through the explicit reset to 0 at WINDOW-1.

## Timing
- Reset (rst_n=0 at a rising edge): `dout`, `win_out`, and `win_cnt` are 0; `win_valid` is 0. Reset beats clr and din_valid.
- Latency:
  - `dout` reflects a sample 1 cycle after acceptance.
  - `win_out` and `win_valid` appear 1 cycle after the closing sample.
- Throughput: one sample per cycle, with no backpressure.
- Reset mid-window: the partial window is discarded and no win_valid is produced.
- Outputs are registers only. There are no combinational paths from inputs to outputs.

## Configuration
- `XOR_ACCUM_POPCNT_EN` defined:
  - Adds output `win_ones` (clog2(WIDTH+1) bits), equal to the popcount of the `wacc ^ din` value loaded into `win_out`.
  - It is registered in the same cycle as `win_out`, resets to 0, and holds on clr.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then 3 idle cycles -> dout=0x00, win_out=0x00, win_cnt=0, win_valid never 1.
- WIDTH=8, WINDOW=4; accept 0x01, 0x02, 0x04, 0x08 back-to-back -> dout 0x01, 0x03, 0x07, 0x0F; win_cnt 1, 2, 3, 0; win_valid=1 for exactly one cycle with win_out=0x0F (win_ones=4 if enabled).
- Continue with 0xFF ×4 -> dout 0xF0, 0x0F, 0xF0, 0x0F; second window gives win_out=0x00, win_ones=0.
- Accept 0xAA, then din_valid=0 for 5 cycles with din=0x55, then accept 0xAA -> dout 0xAA, held, then 0x00; win_cnt 1, held, 2; no win_valid.
- Accept 3 samples, then clr=1 with din_valid=1 and din=0x11 at the 4th -> no win_valid; dout=0, win_cnt=0, win_out unchanged; the next 4 samples form a full window.
- rst_n=0 for one cycle with din_valid=1 at win_cnt=3 -> all outputs 0 next cycle; no win_valid; counting restarts from 0.

Source files
------------

// File: rtl/xor_accum_window.sv
// xor_accum_window: running and windowed XOR accumulator.
// dout accumulates every accepted sample until clr or reset; the window
// accumulator closes every WINDOW accepted samples, loading win_out and
// pulsing win_valid for one cycle.
// Optional feature macro: XOR_ACCUM_POPCNT_EN adds win_ones, the popcount
// of each closed window value.
module xor_accum_window #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      clr,
    output logic [WIDTH-1:0]          dout,
    output logic [WIDTH-1:0]          win_out,
    output logic                      win_valid,
    output logic [$clog2(WINDOW)-1:0] win_cnt
`ifdef XOR_ACCUM_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] win_ones
`endif
);

    localparam int CNT_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    logic [WIDTH-1:0] wacc;
    logic [WIDTH-1:0] wacc_next;
    logic             accept;
    logic             closing;

    // Sample qualification and the value a closing window would load.
    always_comb begin
        accept    = din_valid && !clr;
        closing   = accept && (win_cnt == CNT_LAST);
        wacc_next = wacc ^ din;
    end

    // Accumulators, window counter and closure pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout      <= '0;
            wacc      <= '0;
            win_cnt   <= '0;
            win_out   <= '0;
            win_valid <= 1'b0;
        end else if (clr) begin
            // win_out deliberately keeps the last completed window.
            dout      <= '0;
            wacc      <= '0;
            win_cnt   <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            if (accept) begin
                dout <= dout ^ din;
                if (closing) begin
                    win_out   <= wacc_next;
                    win_valid <= 1'b1;
                    wacc      <= '0;
                    win_cnt   <= '0;
                end else begin
                    wacc    <= wacc_next;
                    win_cnt <= win_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef XOR_ACCUM_POPCNT_EN
    localparam int ONES_W = $clog2(WIDTH + 1);

    logic [ONES_W-1:0] ones_next;

    // Popcount of the value being loaded into win_out.
    always_comb begin
        ones_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_next = ones_next + ONES_W'(wacc_next[i]);
        end
    end

    // win_ones tracks win_out: loaded on closure, held on clr, zeroed on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_ones <= '0;
        end else if (closing) begin
            win_ones <= ones_next;
        end
    end
`endif

endmodule

// File: tb/tb_xor_accum_window.sv
// Directed, table-driven bench for xor_accum_window with WIDTH=8, WINDOW=4.
module tb_xor_accum_window;

    localparam int WIDTH  = 8;
    localparam int WINDOW = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             clr;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] win_out;
    logic             win_valid;
    logic [1:0]       win_cnt;
`ifdef XOR_ACCUM_POPCNT_EN
    logic [3:0]       win_ones;
`endif

    xor_accum_window #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .clr       (clr),
        .dout      (dout),
        .win_out   (win_out),
        .win_valid (win_valid),
        .win_cnt   (win_cnt)
`ifdef XOR_ACCUM_POPCNT_EN
        ,
        .win_ones  (win_ones)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       clr;
        logic       vld;
        logic [7:0] din;
        logic [7:0] e_dout;
        logic [7:0] e_wout;
        logic       e_wv;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic c, input logic v, input logic [7:0] d,
                       input logic [7:0] ed, input logic [7:0] ew, input logic ev,
                       input logic [1:0] ec);
        vec_t t;
        t.rst_n = r; t.clr = c; t.vld = v; t.din = d;
        t.e_dout = ed; t.e_wout = ew; t.e_wv = ev; t.e_cnt = ec;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    int pulses;
    int consec;
    logic prev_wv;

    initial begin
        rst_n = 1'b0; clr = 1'b0; din_valid = 1'b0; din = '0;

        //  rst clr vld din    dout   wout   wv cnt
        add(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        add(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        // first window
        add(1, 0, 1, 8'h01, 8'h01, 8'h00, 0, 1);
        add(1, 0, 1, 8'h02, 8'h03, 8'h00, 0, 2);
        add(1, 0, 1, 8'h04, 8'h07, 8'h00, 0, 3);
        add(1, 0, 1, 8'h08, 8'h0F, 8'h0F, 1, 0);
        // second window of 0xFF
        add(1, 0, 1, 8'hFF, 8'hF0, 8'h0F, 0, 1);
        add(1, 0, 1, 8'hFF, 8'h0F, 8'h0F, 0, 2);
        add(1, 0, 1, 8'hFF, 8'hF0, 8'h0F, 0, 3);
        add(1, 0, 1, 8'hFF, 8'h0F, 8'h00, 1, 0);
        add(1, 0, 0, 8'h00, 8'h0F, 8'h00, 0, 0);
        // clr, then gapped samples
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        add(1, 0, 1, 8'hAA, 8'hAA, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) add(1, 0, 0, 8'h55, 8'hAA, 8'h00, 0, 1);
        add(1, 0, 1, 8'hAA, 8'h00, 8'h00, 0, 2);
        // close a window with a nonzero result
        add(1, 0, 1, 8'h33, 8'h33, 8'h00, 0, 3);
        add(1, 0, 1, 8'h44, 8'h77, 8'h77, 1, 0);
        // three samples, then clr beats a would-be closing sample
        add(1, 0, 1, 8'h10, 8'h67, 8'h77, 0, 1);
        add(1, 0, 1, 8'h20, 8'h47, 8'h77, 0, 2);
        add(1, 0, 1, 8'h40, 8'h07, 8'h77, 0, 3);
        add(1, 1, 1, 8'h11, 8'h00, 8'h77, 0, 0);
        add(1, 0, 1, 8'h01, 8'h01, 8'h77, 0, 1);
        add(1, 0, 1, 8'h02, 8'h03, 8'h77, 0, 2);
        add(1, 0, 1, 8'h04, 8'h07, 8'h77, 0, 3);
        add(1, 0, 1, 8'h80, 8'h87, 8'h87, 1, 0);
        // reset mid-window with a would-be closing sample
        add(1, 0, 1, 8'h05, 8'h82, 8'h87, 0, 1);
        add(1, 0, 1, 8'h06, 8'h84, 8'h87, 0, 2);
        add(1, 0, 1, 8'h07, 8'h83, 8'h87, 0, 3);
        add(0, 0, 1, 8'h09, 8'h00, 8'h00, 0, 0);
        add(1, 0, 1, 8'h0A, 8'h0A, 8'h00, 0, 1);
        add(1, 0, 1, 8'h0B, 8'h01, 8'h00, 0, 2);
        add(1, 0, 1, 8'h0C, 8'h0D, 8'h00, 0, 3);
        add(1, 0, 1, 8'h1D, 8'h10, 8'h10, 1, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; clr = vecs[i].clr;
            din_valid = vecs[i].vld; din = vecs[i].din;
            @(posedge clk);
            #1;
            chk("dout",      i, 32'(dout),      32'(vecs[i].e_dout));
            chk("win_out",   i, 32'(win_out),   32'(vecs[i].e_wout));
            chk("win_valid", i, 32'(win_valid), 32'(vecs[i].e_wv));
            chk("win_cnt",   i, 32'(win_cnt),   32'(vecs[i].e_cnt));
`ifdef XOR_ACCUM_POPCNT_EN
            chk("win_ones",  i, 32'(win_ones),  32'($countones(vecs[i].e_wout)));
`endif
        end

        // Two back-to-back windows: exactly two isolated one-cycle pulses.
        @(negedge clk);
        rst_n = 1'b1; clr = 1'b1; din_valid = 1'b0;
        pulses = 0; consec = 0; prev_wv = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            clr = 1'b0;
            din_valid = (k < 8);
            din = 8'(k + 1);
            @(posedge clk);
            #1;
            if (win_valid) pulses++;
            if (win_valid && prev_wv) consec++;
            prev_wv = win_valid;
        end
        chk("b2b_pulses",      100, 32'(pulses),  32'd2);
        chk("b2b_consecutive", 101, 32'(consec),  32'd0);
        chk("b2b_win_out",     102, 32'(win_out), 32'h0C);
        chk("b2b_dout",        103, 32'(dout),    32'h08);
        chk("b2b_win_cnt",     104, 32'(win_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
